// File: rtl/spi_bridge_pkg.sv
// Shared types and constants for the SPI shift engine and its clock divider.
// State encoding is fixed so that the manager side can decode it if ever exported.
package spi_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [7:0] CS_IDLE    = 8'hFF;
  localparam int         DATA_W     = 8;
  localparam int         XFER_TICKS = 18;

  // True when exactly one active-low select line is asserted.
  function automatic logic onehot_low_ok(input logic [7:0] sel);
    return $countones(~sel) == 1;
  endfunction

endpackage

// File: rtl/spi_shift_engine_if.sv
// Manager-facing request/response signals plus the SPI pins of the shift engine.
// The engine is the slave modport; the manager (and the attached SPI device) is the master.
interface spi_shift_engine_if #(
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 8
);
  logic                  SPI_start;
  logic [0:NUM_SLAVES-1] SPI_select;
  logic                  SPI_busy;
  logic [DATA_W-1:0]     tx_data;
  logic [DATA_W-1:0]     rx_data;
  logic                  rx_valid;
  logic                  SCLK;
  logic                  MOSI;
  logic                  MISO;
  logic [0:NUM_SLAVES-1] CS_N;

  modport master (
    output SPI_start, SPI_select, tx_data, MISO,
    input  SPI_busy, rx_data, rx_valid, SCLK, MOSI, CS_N
  );

  modport slave (
    input  SPI_start, SPI_select, tx_data, MISO,
    output SPI_busy, rx_data, rx_valid, SCLK, MOSI, CS_N
  );
endinterface

// File: rtl/spi_clk_divider.sv
// Free-running SPICLK reference: tick every CLK_DIV cycles, SPICLK toggles on each tick.
// rise_tick flags the tick on which SPICLK goes 0->1; no backpressure, never stalls.
module spi_clk_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic ACLK,
  input  logic reset,
  output logic tick,
  output logic rise_tick,
  output logic SPICLK
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          spiclk_q, spiclk_d;

  assign tick      = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_tick = tick & ~spiclk_q;
  assign SPICLK    = spiclk_q;

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    spiclk_d = spiclk_q ^ tick;
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      cnt_q    <= '0;
      spiclk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      spiclk_q <= spiclk_d;
    end
  end

endmodule

// File: rtl/spi_shift_engine.sv
// One DATA_W-bit SPI mode-0 transfer, MSB first, captured on a rising SPICLK tick; busy for 18 ticks.
// Starts while busy are ignored, and a start held across completion must drop before it retriggers.
module spi_shift_engine #(
  parameter int CLK_DIV    = 4,
  parameter int DATA_W     = 8,
  parameter int NUM_SLAVES = 8
) (
  input  logic              ACLK,
  input  logic              reset,
  output logic              SPICLK,
  spi_shift_engine_if.slave bus
);
  import spi_bridge_pkg::*;

  localparam int BCW = $clog2(DATA_W);

  logic tick, rise_tick;

  state_e                state_q, state_d;
  logic                  armed_q, armed_d;
  logic                  busy_q, busy_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic [0:NUM_SLAVES-1] sel_q, sel_d;
  logic                  sel_err_q, sel_err_d;
  logic [DATA_W-1:0]     tx_sr_q, tx_sr_d;
  logic [DATA_W-1:0]     rx_sr_q, rx_sr_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]     rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;

  spi_clk_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .ACLK     (ACLK),
    .reset    (reset),
    .tick     (tick),
    .rise_tick(rise_tick),
    .SPICLK   (SPICLK)
  );

  assign bus.SPI_busy = busy_q;
  assign bus.SCLK     = sclk_q;
  assign bus.MOSI     = mosi_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  // Selects follow busy, so they release on the same edge that busy drops.
  assign bus.CS_N     = (busy_q && !sel_err_q) ? sel_q : NUM_SLAVES'(CS_IDLE);

  always_comb begin
    state_d    = state_q;
    armed_d    = armed_q;
    busy_d     = busy_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    sel_d      = sel_q;
    sel_err_d  = sel_err_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    bit_cnt_d  = bit_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!bus.SPI_start) armed_d = 1'b1;
        if (rise_tick && bus.SPI_start && armed_q) begin
          tx_sr_d   = bus.tx_data;
          sel_d     = bus.SPI_select;
          sel_err_d = !onehot_low_ok(bus.SPI_select);
          busy_d    = 1'b1;
          mosi_d    = bus.tx_data[DATA_W-1];
          sclk_d    = 1'b0;
          armed_d   = 1'b0;
          bit_cnt_d = '0;
          rx_sr_d   = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (!sclk_q) begin
            sclk_d  = 1'b1;
            rx_sr_d = {rx_sr_q[DATA_W-2:0], bus.MISO & ~sel_err_q};
          end else begin
            sclk_d = 1'b0;
            // The last falling edge leaves MOSI on bit 0 rather than shifting further.
            if (bit_cnt_q == BCW'(DATA_W - 1)) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
              tx_sr_d   = tx_sr_q << 1;
              mosi_d    = tx_sr_q[DATA_W-2];
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          sclk_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (tick) begin
          busy_d     = 1'b0;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          state_d    = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (reset) begin
      state_q    <= IDLE;
      armed_q    <= 1'b1;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      sel_q      <= '1;
      sel_err_q  <= 1'b0;
      tx_sr_q    <= '0;
      rx_sr_q    <= '0;
      bit_cnt_q  <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      armed_q    <= armed_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      sel_q      <= sel_d;
      sel_err_q  <= sel_err_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
    end
  end

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: vector table of complete transfers plus
// hand-written sequences for held start, start during SPICLK high, and mid-transfer reset.
module tb_spi_shift_engine;
  import spi_bridge_pkg::*;

  localparam int CLK_DIV  = 4;
  localparam int BUSY_CYC = XFER_TICKS * CLK_DIV;

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sel;
    logic       loop;
    logic [7:0] pat;
    logic [7:0] exp_rx;
    logic [7:0] exp_cs;
  } vec_t;

  logic ACLK = 1'b0;
  logic reset;
  logic SPICLK;

  spi_shift_engine_if #(.DATA_W(8), .NUM_SLAVES(8)) bus ();

  spi_shift_engine #(.CLK_DIV(CLK_DIV), .DATA_W(8), .NUM_SLAVES(8)) dut (
    .ACLK  (ACLK),
    .reset (reset),
    .SPICLK(SPICLK),
    .bus   (bus)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic miso_bit(input vec_t v, input int rises, input logic mosi);
    if (v.loop) return mosi;
    if (rises >= 8) return 1'b0;
    return v.pat[3'(7 - rises)];
  endfunction

  task automatic wait_busy(input logic lvl, input int bound, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge ACLK);
      if (bus.SPI_busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int   lat, bcnt, rises, cs_bad, mosi_bad, vld_cnt;
    logic sp, mp;
    bit   ok;
    bus.tx_data    = v.tx;
    bus.SPI_select = v.sel;
    rises          = 0;
    bus.MISO       = miso_bit(v, 0, bus.MOSI);
    bus.SPI_start  = 1'b1;
    lat = 0;
    ok  = 1'b0;
    for (int i = 0; i < 2 * CLK_DIV + 2; i++) begin
      @(negedge ACLK);
      lat++;
      bus.MISO = miso_bit(v, 0, bus.MOSI);
      if (bus.SPI_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk({tag, "_capture_latency"}, int'(ok && lat >= 1 && lat <= 2 * CLK_DIV), 1);
    bus.SPI_start  = 1'b0;
    bus.tx_data    = ~v.tx;
    bus.SPI_select = 8'h00;
    bcnt     = 1;
    cs_bad   = int'(bus.CS_N !== v.exp_cs);
    mosi_bad = 0;
    vld_cnt  = int'(bus.rx_valid);
    sp = bus.SCLK;
    mp = bus.MOSI;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (!bus.SPI_busy) begin
        ok = 1'b1;
        break;
      end
      bcnt++;
      if (bus.CS_N !== v.exp_cs) cs_bad++;
      if (sp == 1'b0 && bus.SCLK == 1'b1) rises++;
      if (bus.MOSI !== mp && !(sp == 1'b1 && bus.SCLK == 1'b0)) mosi_bad++;
      vld_cnt += int'(bus.rx_valid);
      sp = bus.SCLK;
      mp = bus.MOSI;
      bus.MISO = miso_bit(v, rises, bus.MOSI);
    end
    chk({tag, "_busy_dropped"}, int'(ok), 1);
    chk({tag, "_busy_cycles"}, bcnt, BUSY_CYC);
    chk({tag, "_rx_valid_at_done"}, int'(bus.rx_valid), 1);
    chk({tag, "_rx_data"}, int'(bus.rx_data), int'(v.exp_rx));
    chk({tag, "_cs_n_bad_cycles"}, cs_bad, 0);
    chk({tag, "_sclk_rises"}, rises, 8);
    chk({tag, "_mosi_off_fall_changes"}, mosi_bad, 0);
    chk({tag, "_cs_n_after"}, int'(bus.CS_N), int'(CS_IDLE));
    chk({tag, "_sclk_idle"}, int'(bus.SCLK), 0);
    vld_cnt += int'(bus.rx_valid);
    repeat (10) begin
      @(negedge ACLK);
      vld_cnt += int'(bus.rx_valid);
    end
    chk({tag, "_rx_valid_pulses"}, vld_cnt, 1);
    chk({tag, "_rx_data_held"}, int'(bus.rx_data), int'(v.exp_rx));
  endtask

  vec_t vecs[4];

  initial begin
    bit   ok;
    int   cnt, bad, rises;
    logic sp, seen_low;

    vecs[0] = '{8'hA5, 8'h7F, 1'b1, 8'h00, 8'hA5, 8'h7F};
    vecs[1] = '{8'hE7, 8'hFB, 1'b0, 8'h3C, 8'h3C, 8'hFB};
    vecs[2] = '{8'h5A, 8'hFF, 1'b1, 8'h00, 8'h00, 8'hFF};
    vecs[3] = '{8'h96, 8'hFE, 1'b1, 8'h00, 8'h96, 8'hFE};

    reset          = 1'b1;
    bus.SPI_start  = 1'b0;
    bus.SPI_select = 8'hFF;
    bus.tx_data    = 8'h00;
    bus.MISO       = 1'b0;
    repeat (3) @(negedge ACLK);
    chk("reset_spiclk", int'(SPICLK), 0);
    chk("reset_sclk", int'(bus.SCLK), 0);
    chk("reset_mosi", int'(bus.MOSI), 0);
    chk("reset_cs_n", int'(bus.CS_N), int'(CS_IDLE));
    chk("reset_busy", int'(bus.SPI_busy), 0);
    chk("reset_rx_data", int'(bus.rx_data), 0);
    chk("reset_rx_valid", int'(bus.rx_valid), 0);
    reset = 1'b0;
    repeat (2) @(negedge ACLK);

    for (int i = 0; i < 4; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Start held high across completion must not retrigger until it drops.
    bus.tx_data    = 8'h5A;
    bus.SPI_select = 8'hBF;
    bus.MISO       = 1'b0;
    bus.SPI_start  = 1'b1;
    wait_busy(1'b1, 2 * CLK_DIV + 2, ok);
    chk("held_first_capture", int'(ok), 1);
    wait_busy(1'b0, 200, ok);
    chk("held_first_done", int'(ok), 1);
    cnt = 0;
    repeat (6 * CLK_DIV) begin
      @(negedge ACLK);
      cnt += int'(bus.SPI_busy);
    end
    chk("held_no_retrigger", cnt, 0);
    bus.SPI_start = 1'b0;
    @(negedge ACLK);
    bus.SPI_start = 1'b1;
    wait_busy(1'b1, 2 * CLK_DIV + 2, ok);
    chk("held_rearm_capture", int'(ok), 1);
    bus.SPI_start = 1'b0;
    wait_busy(1'b0, 200, ok);
    chk("held_second_done", int'(ok), 1);

    // Start raised while SPICLK is high waits for the next rising tick.
    ok = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(negedge ACLK);
      if (SPICLK === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk("hi_phase_found", int'(ok), 1);
    bus.SPI_start = 1'b1;
    bad = 0;
    seen_low = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 4 * CLK_DIV; i++) begin
      @(negedge ACLK);
      if (SPICLK == 1'b0) seen_low = 1'b1;
      if (!seen_low || SPICLK == 1'b0) begin
        bad += int'(bus.SPI_busy);
      end else begin
        ok = bus.SPI_busy;
        break;
      end
    end
    chk("hi_phase_no_early_capture", bad, 0);
    chk("hi_phase_busy_with_spiclk", int'(ok), 1);
    bus.SPI_start = 1'b0;
    wait_busy(1'b0, 200, ok);
    chk("hi_phase_done", int'(ok), 1);
    repeat (2) @(negedge ACLK);

    // Reset in the middle of a transfer, at the third SCLK rise.
    bus.tx_data    = 8'hC3;
    bus.SPI_select = 8'h7F;
    bus.SPI_start  = 1'b1;
    wait_busy(1'b1, 2 * CLK_DIV + 2, ok);
    chk("mid_reset_capture", int'(ok), 1);
    bus.SPI_start = 1'b0;
    rises = 0;
    sp = bus.SCLK;
    for (int i = 0; i < 200; i++) begin
      @(negedge ACLK);
      if (sp == 1'b0 && bus.SCLK == 1'b1) rises++;
      sp = bus.SCLK;
      if (rises == 3) break;
    end
    chk("mid_reset_third_rise", rises, 3);
    reset = 1'b1;
    @(negedge ACLK);
    chk("mid_reset_cs_n", int'(bus.CS_N), int'(CS_IDLE));
    chk("mid_reset_sclk", int'(bus.SCLK), 0);
    chk("mid_reset_busy", int'(bus.SPI_busy), 0);
    chk("mid_reset_spiclk", int'(SPICLK), 0);
    chk("mid_reset_rx_data", int'(bus.rx_data), 0);
    reset = 1'b0;
    @(negedge ACLK);
    run_vec('{8'h81, 8'h7F, 1'b1, 8'h00, 8'h81, 8'h7F}, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
